mac_neuron_seq: RTL and testbench



---
 rtl/neuron_pkg.sv | 49 ++++
 rtl/mac_unit.sv | 46 ++++
 rtl/mac_neuron_seq.sv | 164 ++++++++++++++++
 tb/tb_mac_neuron_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared constants, state encoding and helpers for the time-multiplexed neuron.
package neuron_pkg;

  localparam int unsigned ACT_NONE = 0;
  localparam int unsigned ACT_RELU = 1;

  // Wide intermediate width used to move values between ACC_W and OUT_W domains.
  localparam int unsigned WIDE_W = 64;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_MAC  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  typedef struct packed {
    logic [WIDE_W-1:0] value;
    logic              flag;
  } sat_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Clamp a signed value to the two's complement range of out_w bits.
  function automatic sat_t saturate(input logic signed [WIDE_W-1:0] acc,
                                    input int unsigned out_w);
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    sat_t r;
    hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    r.value = acc;
    r.flag  = 1'b0;
    if (acc > hi) begin
      r.value = hi;
      r.flag  = 1'b1;
    end else if (acc < lo) begin
      r.value = lo;
      r.flag  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Sign-aware X_W x W_W multiplier feeding a loadable accumulator register.
module mac_unit #(
  parameter int unsigned X_W      = 10,
  parameter int unsigned W_W      = 8,
  parameter int unsigned W_SIGNED = 0,
  parameter int unsigned ACC_W    = 23
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic signed [ACC_W-1:0] load_val_i,
  input  logic                    en_i,
  input  logic [X_W-1:0]          x_i,
  input  logic [W_W-1:0]          w_i,
  output logic signed [ACC_W-1:0] acc_o
);

  localparam int unsigned PROD_W = X_W + W_W + 2;

  logic signed [PROD_W-1:0] w_x_ext;
  logic signed [PROD_W-1:0] w_w_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     w_w_msb;

  // x is always unsigned; w follows W_SIGNED.
  assign w_w_msb    = (W_SIGNED != 0) & w_i[W_W-1];
  assign w_x_ext    = {{(PROD_W - X_W){1'b0}}, x_i};
  assign w_w_ext    = {{(PROD_W - W_W){w_w_msb}}, w_i};
  assign w_prod     = w_x_ext * w_w_ext;
  assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc <= '0;
    end else if (load_i) begin
      r_acc <= load_val_i;
    end else if (en_i) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign acc_o = r_acc;

endmodule

// File: rtl/mac_neuron_seq.sv
// Time-multiplexed neuron: one product per cycle, bias, optional ReLU, saturation,
// valid/ready result handshake.
module mac_neuron_seq
  import neuron_pkg::*;
#(
  parameter int unsigned N_INPUTS = 8,
  parameter int unsigned X_W      = 10,
  parameter int unsigned W_W      = 8,
  parameter int unsigned W_SIGNED = 0,
  parameter int unsigned OUT_W    = 23,
  parameter int unsigned ACT      = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [N_INPUTS*X_W-1:0]    x_i,
  input  logic [N_INPUTS*W_W-1:0]    w_i,
  input  logic signed [OUT_W-1:0]    bias_i,
  output logic                       busy_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       sat_o,
  output logic signed [OUT_W-1:0]    result_o
);

  localparam int unsigned IDX_W = clog2(N_INPUTS);
  localparam int unsigned ACC_W = X_W + W_W + IDX_W + 2;

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [N_INPUTS*X_W-1:0] r_x;
  logic [N_INPUTS*W_W-1:0] r_w;
  logic                    r_busy;
  logic                    r_valid;
  logic                    r_sat;
  logic signed [OUT_W-1:0] r_result;

  logic                    w_acc_load;
  logic                    w_acc_en;
  logic                    w_out_cap;
  logic [X_W-1:0]          w_x_sel;
  logic [W_W-1:0]          w_w_sel;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [WIDE_W-1:0] w_acc_wide;
  logic signed [WIDE_W-1:0] w_act_wide;
  sat_t                    w_sat;

  // Next-state and datapath control.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_acc_load  = 1'b0;
    w_acc_en    = 1'b0;
    w_out_cap   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_acc_load  = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        w_acc_en = 1'b1;
        if (r_idx == IDX_W'(N_INPUTS - 1)) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_OUT;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      S_OUT: begin
        if (!r_valid) begin
          w_out_cap = 1'b1;
        end else if (ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_x <= '0;
      r_w <= '0;
    end else if (w_acc_load) begin
      r_x <= x_i;
      r_w <= w_i;
    end
  end

  // Operand select for the current MAC step.
  always_comb begin
    w_x_sel = '0;
    w_w_sel = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_x_sel = r_x[k*X_W +: X_W];
        w_w_sel = r_w[k*W_W +: W_W];
      end
    end
  end

  assign w_bias_ext = ACC_W'(WIDE_W'(bias_i));

  mac_unit #(
    .X_W      (X_W),
    .W_W      (W_W),
    .W_SIGNED (W_SIGNED),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_acc_load),
    .load_val_i (w_bias_ext),
    .en_i       (w_acc_en),
    .x_i        (w_x_sel),
    .w_i        (w_w_sel),
    .acc_o      (w_acc)
  );

  assign w_acc_wide = WIDE_W'(w_acc);
  assign w_act_wide = ((ACT == ACT_RELU) && w_acc_wide[WIDE_W-1]) ? '0 : w_acc_wide;
  assign w_sat      = saturate(w_act_wide, OUT_W);

  // Result stage; result and flag are held until the next OUT entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_sat    <= 1'b0;
      r_result <= '0;
    end else begin
      r_busy <= (w_state_nxt inside {S_LOAD, S_MAC, S_OUT});
      if (w_out_cap) begin
        r_result <= OUT_W'(w_sat.value);
        r_sat    <= w_sat.flag;
        r_valid  <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign busy_o   = r_busy;
  assign valid_o  = r_valid;
  assign sat_o    = r_sat;
  assign result_o = r_result;

endmodule

// File: tb/tb_mac_neuron_seq.sv
// Directed self-checking bench for mac_neuron_seq across several parameter sets.
module tb_mac_neuron_seq;

  int n_checks = 0;
  int n_fail   = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut0: defaults; dut1: OUT_W=16 (shares x/w with dut0)
  logic        st0 = 0, rdy0 = 1, busy0, val0, sat0;
  logic [79:0] x0 = '0;
  logic [63:0] w0 = '0;
  logic [22:0] b0 = '0, res0;
  logic        st1 = 0, rdy1 = 1, busy1, val1, sat1;
  logic [15:0] b1 = '0, res1;
  // dut2/dut3: signed weights, ACT none / ReLU, shared stimulus
  logic        st2 = 0, rdy2 = 1, busy2, val2, sat2, busy3, val3, sat3;
  logic [79:0] x2 = '0;
  logic [63:0] w2 = '0;
  logic [22:0] b2 = '0, res2, res3;
  // dut4: N_INPUTS=3, X_W=4, W_W=4
  logic        st4 = 0, rdy4 = 1, busy4, val4, sat4;
  logic [11:0] x4 = '0, w4 = '0;
  logic [22:0] b4 = '0, res4;

  mac_neuron_seq dut0 (.clk_i(clk), .rst_i(rst), .start_i(st0), .x_i(x0), .w_i(w0),
    .bias_i(b0), .busy_o(busy0), .valid_o(val0), .ready_i(rdy0), .sat_o(sat0), .result_o(res0));

  mac_neuron_seq #(.OUT_W(16)) dut1 (.clk_i(clk), .rst_i(rst), .start_i(st1), .x_i(x0),
    .w_i(w0), .bias_i(b1), .busy_o(busy1), .valid_o(val1), .ready_i(rdy1), .sat_o(sat1),
    .result_o(res1));

  mac_neuron_seq #(.W_SIGNED(1), .ACT(0)) dut2 (.clk_i(clk), .rst_i(rst), .start_i(st2),
    .x_i(x2), .w_i(w2), .bias_i(b2), .busy_o(busy2), .valid_o(val2), .ready_i(rdy2),
    .sat_o(sat2), .result_o(res2));

  mac_neuron_seq #(.W_SIGNED(1), .ACT(1)) dut3 (.clk_i(clk), .rst_i(rst), .start_i(st2),
    .x_i(x2), .w_i(w2), .bias_i(b2), .busy_o(busy3), .valid_o(val3), .ready_i(rdy2),
    .sat_o(sat3), .result_o(res3));

  mac_neuron_seq #(.N_INPUTS(3), .X_W(4), .W_W(4)) dut4 (.clk_i(clk), .rst_i(rst),
    .start_i(st4), .x_i(x4), .w_i(w4), .bias_i(b4), .busy_o(busy4), .valid_o(val4),
    .ready_i(rdy4), .sat_o(sat4), .result_o(res4));

  function automatic logic val_of(input int d);
    case (d)
      0:       return val0;
      1:       return val1;
      2:       return val2;
      default: return val4;
    endcase
  endfunction

  task automatic set_start(input int d, input logic v);
    case (d)
      0:       st0 = v;
      1:       st1 = v;
      2:       st2 = v;
      default: st4 = v;
    endcase
  endtask

  // Called at a negedge: pulse start over one edge, then count edges until valid.
  task automatic start_and_wait(input int d, output int cnt);
    set_start(d, 1'b1);
    @(posedge clk);
    #1 set_start(d, 1'b0);
    cnt = 0;
    while (cnt < 40) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (val_of(d)) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy0, val0, sat0} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=000", {busy0, val0, sat0});
    end
    n_checks++;
    if (res0 !== 23'd0) begin
      n_fail++; $display("FAIL reset_result got=%0d exp=0", res0);
    end
    n_checks++;
    if ({val1, val2, val3, val4, busy4} !== 5'b0) begin
      n_fail++; $display("FAIL reset_others got=%b exp=00000", {val1, val2, val3, val4, busy4});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_scale();
    int cnt;
    for (int k = 0; k < 8; k++) begin
      x0[k*10 +: 10] = 10'd1023;
      w0[k*8 +: 8]   = 8'd255;
    end
    b0 = '0; rdy0 = 1'b1;
    start_and_wait(0, cnt);
    n_checks++;
    if (cnt != 9) begin n_fail++; $display("FAIL full_latency got=%0d exp=9", cnt); end
    n_checks++;
    if (res0 !== 23'd2086920) begin
      n_fail++; $display("FAIL full_result got=%0d exp=2086920", res0);
    end
    n_checks++;
    if ({sat0, busy0} !== 2'b01) begin
      n_fail++; $display("FAIL full_sat_busy got=%b exp=01", {sat0, busy0});
    end
    @(negedge clk);
    n_checks++;
    if ({val0, busy0} !== 2'b00 || res0 !== 23'd2086920) begin
      n_fail++; $display("FAIL full_after_hs val_busy=%b res=%0d exp=00/2086920", {val0, busy0}, res0);
    end
  endtask

  task automatic test_saturate();
    int cnt;
    b1 = '0; rdy1 = 1'b1;
    start_and_wait(1, cnt);
    n_checks++;
    if (cnt != 9 || res1 !== 16'd32767 || sat1 !== 1'b1) begin
      n_fail++; $display("FAIL sat16 cnt=%0d res=%0d sat=%b exp=9/32767/1", cnt, res1, sat1);
    end
    @(negedge clk);
  endtask

  task automatic test_signed();
    int cnt;
    x2 = '0; w2 = '0;
    x2[9:0] = 10'd100;
    w2[7:0] = 8'h80;
    b2 = 23'd5; rdy2 = 1'b1;
    start_and_wait(2, cnt);
    n_checks++;
    if (cnt != 9 || res2 !== 23'(-12795) || sat2 !== 1'b0) begin
      n_fail++; $display("FAIL signed_none cnt=%0d res=%0d sat=%b exp=9/-12795/0",
                         cnt, $signed(res2), sat2);
    end
    n_checks++;
    if (val3 !== 1'b1 || res3 !== 23'd0 || sat3 !== 1'b0) begin
      n_fail++; $display("FAIL signed_relu val=%b res=%0d sat=%b exp=1/0/0", val3, res3, sat3);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    int cnt;
    bit held_ok;
    for (int k = 0; k < 8; k++) begin
      x0[k*10 +: 10] = 10'd1;
      w0[k*8 +: 8]   = 8'(k + 1);
    end
    b0 = 23'(-6); rdy0 = 1'b0;
    start_and_wait(0, cnt);
    n_checks++;
    if (cnt != 9 || res0 !== 23'd30) begin
      n_fail++; $display("FAIL stall_first cnt=%0d res=%0d exp=9/30", cnt, res0);
    end
    held_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        for (int k = 0; k < 8; k++) begin
          x0[k*10 +: 10] = 10'd2;
          w0[k*8 +: 8]   = 8'd3;
        end
        b0 = '0; st0 = 1'b1;
      end else begin
        st0 = 1'b0;
      end
      @(negedge clk);
      if (val0 !== 1'b1 || res0 !== 23'd30) held_ok = 1'b0;
    end
    st0 = 1'b0;
    n_checks++;
    if (!held_ok) begin
      n_fail++; $display("FAIL stall_hold val=%b res=%0d exp=1/30", val0, res0);
    end
    rdy0 = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({val0, busy0} !== 2'b00) begin
      n_fail++; $display("FAIL stall_release val_busy=%b exp=00", {val0, busy0});
    end
    start_and_wait(0, cnt);
    n_checks++;
    if (cnt != 9 || res0 !== 23'd48) begin
      n_fail++; $display("FAIL stall_next cnt=%0d res=%0d exp=9/48", cnt, res0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mac();
    int cnt;
    for (int k = 0; k < 8; k++) begin
      x0[k*10 +: 10] = 10'd1023;
      w0[k*8 +: 8]   = 8'd255;
    end
    b0 = '0; rdy0 = 1'b1;
    st0 = 1'b1;
    @(posedge clk);
    #1 st0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy0, val0} !== 2'b00 || res0 !== 23'd0) begin
      n_fail++; $display("FAIL rst_mid busy_val=%b res=%0d exp=00/0", {busy0, val0}, res0);
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      x0[k*10 +: 10] = 10'd1;
      w0[k*8 +: 8]   = 8'd1;
    end
    b0 = 23'd100;
    start_and_wait(0, cnt);
    n_checks++;
    if (cnt != 9 || res0 !== 23'd108 || sat0 !== 1'b0) begin
      n_fail++; $display("FAIL rst_restart cnt=%0d res=%0d sat=%b exp=9/108/0", cnt, res0, sat0);
    end
    @(negedge clk);
  endtask

  task automatic test_small();
    int cnt;
    x4 = {4'd2, 4'd1, 4'd15};
    w4 = {4'd0, 4'd3, 4'd15};
    b4 = 23'(-10); rdy4 = 1'b1;
    start_and_wait(3, cnt);
    n_checks++;
    if (cnt != 4) begin n_fail++; $display("FAIL small_latency got=%0d exp=4", cnt); end
    n_checks++;
    if (res4 !== 23'd218 || sat4 !== 1'b0) begin
      n_fail++; $display("FAIL small_result res=%0d sat=%b exp=218/0", res4, sat4);
    end
    @(negedge clk);
    n_checks++;
    if (val4 !== 1'b0) begin n_fail++; $display("FAIL small_hs val=%b exp=0", val4); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_scale();
    test_saturate();
    test_signed();
    test_stall();
    test_reset_mid_mac();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
